// File: rtl/pong_rally_ctrl.sv
// pong_rally_ctrl: serve/hit/miss rally sequencer, scoring and win flags for an LED ping-pong track.
// Define SPEEDUP_EN to shorten the step interval by one tick after every successful hit.
module pong_rally_ctrl #(
    parameter int N_LEDS    = 18,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 5,
    parameter int RATE_INIT = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               tick_i,
    input  logic               start_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    output logic [N_LEDS-1:0]  leds_o,
    output logic [SCORE_W-1:0] score_left_o,
    output logic [SCORE_W-1:0] score_right_o,
    output logic               left_full_flag_o,
    output logic               right_full_flag_o
);
    localparam int PW = $clog2(N_LEDS);
    localparam int RW = $clog2(RATE_INIT + 1);
    localparam logic [PW-1:0] LEFT_END = PW'(N_LEDS - 1);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [RW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      rate;
    logic [SCORE_W-1:0] sc_l_q, sc_l_d, sc_r_q, sc_r_d, sc_l_inc, sc_r_inc;
    logic dir_r_q, dir_r_d, srv_l_q, srv_l_d;
    logic flag_l_q, flag_l_d, flag_r_q, flag_r_d;
    logic lock_l_q, lock_l_d, lock_r_q, lock_r_d;
    logic start_q, btn_l_q, btn_r_q;
    logic press_s, press_l, press_r, recv_press, recv_lock, at_end, hit, step;

`ifdef SPEEDUP_EN
    logic [RW-1:0] rate_q, rate_d;
    assign rate = rate_q;
`else
    assign rate = RW'(RATE_INIT);
`endif

    assign press_s    = start_i & ~start_q;
    assign press_l    = btn_left_i & ~btn_l_q;
    assign press_r    = btn_right_i & ~btn_r_q;
    // dir_r_q set means the ball travels toward index 0, so the right player receives
    assign recv_press = dir_r_q ? press_r : press_l;
    assign recv_lock  = dir_r_q ? lock_r_q : lock_l_q;
    assign at_end     = dir_r_q ? (pos_q == '0) : (pos_q == LEFT_END);
    assign hit        = recv_press & at_end & ~recv_lock;
    assign step       = tick_i & (cnt_q == rate - RW'(1));
    assign sc_l_inc   = sc_l_q + SCORE_W'(1);
    assign sc_r_inc   = sc_r_q + SCORE_W'(1);

    assign leds_o = (state_q == IDLE) ? '0 :
                    (state_q == OVER) ? '1 : {{(N_LEDS-1){1'b0}}, 1'b1} << pos_q;
    assign score_left_o      = sc_l_q;
    assign score_right_o     = sc_r_q;
    assign left_full_flag_o  = flag_l_q;
    assign right_full_flag_o = flag_r_q;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        sc_l_d   = sc_l_q;
        sc_r_d   = sc_r_q;
        dir_r_d  = dir_r_q;
        srv_l_d  = srv_l_q;
        flag_l_d = flag_l_q;
        flag_r_d = flag_r_q;
        lock_l_d = lock_l_q;
        lock_r_d = lock_r_q;
`ifdef SPEEDUP_EN
        rate_d   = rate_q;
`endif
        case (state_q)
            SERVE: begin
                cnt_d    = '0;
                lock_l_d = 1'b0;
                lock_r_d = 1'b0;
                pos_d    = srv_l_q ? LEFT_END : '0;
`ifdef SPEEDUP_EN
                rate_d   = RW'(RATE_INIT);
`endif
                if (srv_l_q ? press_l : press_r) begin
                    state_d = PLAY;
                    dir_r_d = srv_l_q;
                end
            end
            PLAY: begin
                if (hit) begin
                    dir_r_d  = ~dir_r_q;
                    lock_l_d = 1'b0;
                    lock_r_d = 1'b0;
                    cnt_d    = '0;
`ifdef SPEEDUP_EN
                    rate_d   = (rate_q > RW'(1)) ? rate_q - RW'(1) : rate_q;
`endif
                end else begin
                    if (recv_press) begin
                        lock_l_d = lock_l_q | ~dir_r_q;
                        lock_r_d = lock_r_q | dir_r_q;
                    end
                    if (step) begin
                        cnt_d = '0;
                        if (at_end) state_d = POINT;
                        else pos_d = dir_r_q ? pos_q - PW'(1) : pos_q + PW'(1);
                    end else if (tick_i) begin
                        cnt_d = cnt_q + RW'(1);
                    end
                end
            end
            POINT: begin
                // the player who lost the point serves next
                if (dir_r_q) begin
                    sc_l_d = sc_l_inc;
                    if (sc_l_inc == SCORE_W'(WIN_SCORE)) begin
                        flag_l_d = 1'b1;
                        state_d  = OVER;
                    end else begin
                        srv_l_d = 1'b0;
                        pos_d   = '0;
                        state_d = SERVE;
                    end
                end else begin
                    sc_r_d = sc_r_inc;
                    if (sc_r_inc == SCORE_W'(WIN_SCORE)) begin
                        flag_r_d = 1'b1;
                        state_d  = OVER;
                    end else begin
                        srv_l_d = 1'b1;
                        pos_d   = LEFT_END;
                        state_d = SERVE;
                    end
                end
            end
            default: begin
                if (press_s) begin
                    sc_l_d   = '0;
                    sc_r_d   = '0;
                    flag_l_d = 1'b0;
                    flag_r_d = 1'b0;
                    srv_l_d  = 1'b1;
                    pos_d    = LEFT_END;
                    state_d  = SERVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            cnt_q    <= '0;
            sc_l_q   <= '0;
            sc_r_q   <= '0;
            dir_r_q  <= 1'b0;
            srv_l_q  <= 1'b1;
            flag_l_q <= 1'b0;
            flag_r_q <= 1'b0;
            lock_l_q <= 1'b0;
            lock_r_q <= 1'b0;
            start_q  <= 1'b0;
            btn_l_q  <= 1'b0;
            btn_r_q  <= 1'b0;
`ifdef SPEEDUP_EN
            rate_q   <= RW'(RATE_INIT);
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            sc_l_q   <= sc_l_d;
            sc_r_q   <= sc_r_d;
            dir_r_q  <= dir_r_d;
            srv_l_q  <= srv_l_d;
            flag_l_q <= flag_l_d;
            flag_r_q <= flag_r_d;
            lock_l_q <= lock_l_d;
            lock_r_q <= lock_r_d;
            start_q  <= start_i;
            btn_l_q  <= btn_left_i;
            btn_r_q  <= btn_right_i;
`ifdef SPEEDUP_EN
            rate_q   <= rate_d;
`endif
        end
    end
endmodule
